// File: rtl/capture_ctl.sv
// Trigger sequencer for the bus-capture buffer: streams snooped bus cycles to
// the capture RAM while armed, latches a masked address trigger and stops after a post-count.
module capture_ctl #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk25,
    input  logic                  res_n,
    input  logic                  bus_strobe,
    input  logic [15:0]           bus_addr,
    input  logic [15:0]           bus_dat,
    input  logic [3:0]            bus_flags,
    input  logic                  reg_wr,
    input  logic [1:0]            reg_sel,
    input  logic [15:0]           reg_wdat,
    output logic [15:0]           reg_rdat,
    output logic                  cap_wr,
    output logic [15:0]           cap_addr,
    output logic [15:0]           cap_dat,
    output logic [3:0]            cap_flags,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2-1:0] trig_pos,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [15:0]           trig_addr_q, trig_mask_q;
    logic [8:0]            post_cnt_q;
    logic [8:0]            remaining_q, remaining_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d, trig_pos_q, trig_pos_d;
    logic                  pre_full_q, pre_full_d;
    logic                  force_q, force_d;
    logic                  cap_wr_q, cap_wr_d;
    logic [15:0]           cap_addr_q, cap_addr_d, cap_dat_q, cap_dat_d;
    logic [3:0]            cap_flags_q, cap_flags_d;
    logic                  done_q, done_d;

    logic                  ctrl_wr_s, arm_s, abort_s, force_wr_s;
    logic [1:0]            st_eff_s;
    logic [DEPTH_LOG2-1:0] idx_base_s;
    logic                  pre_full_base_s, force_eff_s;
    logic                  match_s, store_s, hit_s, post_last_s;

    // Decode the CTRL write; the control action is applied before a coincident strobe.
    always_comb begin
        ctrl_wr_s  = reg_wr && (reg_sel == 2'd0);
        abort_s    = ctrl_wr_s && reg_wdat[1];
        arm_s      = ctrl_wr_s && reg_wdat[0] && !reg_wdat[1];
        force_wr_s = ctrl_wr_s && reg_wdat[2];
        if (abort_s) begin
            st_eff_s = ST_IDLE;
        end else if (arm_s) begin
            st_eff_s = ST_ARMED;
        end else begin
            st_eff_s = state_q;
        end
        if (arm_s) begin
            idx_base_s      = {DEPTH_LOG2{1'b0}};
            pre_full_base_s = 1'b0;
        end else begin
            idx_base_s      = idx_q;
            pre_full_base_s = pre_full_q;
        end
        force_eff_s = ((force_q && !arm_s && !abort_s) || force_wr_s) && (st_eff_s == ST_ARMED);
        match_s     = ((bus_addr ^ trig_addr_q) & trig_mask_q) == 16'h0000;
        store_s     = bus_strobe && ((st_eff_s == ST_ARMED) || (st_eff_s == ST_POST));
        hit_s       = store_s && (st_eff_s == ST_ARMED) && (match_s || force_eff_s);
        post_last_s = store_s && (st_eff_s == ST_POST) && (remaining_q <= 9'd1);
    end

    // FSM next-state logic.
    always_comb begin
        state_d = st_eff_s;
        case (st_eff_s)
            ST_ARMED: begin
                if (hit_s) begin
                    state_d = (post_cnt_q == 9'd0) ? ST_DONE : ST_POST;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_POST: begin
                if (post_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_POST;
                end
            end
            ST_IDLE: state_d = ST_IDLE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output and datapath next values.
    always_comb begin
        cap_wr_d    = store_s;
        cap_addr_d  = cap_addr_q;
        cap_dat_d   = cap_dat_q;
        cap_flags_d = cap_flags_q;
        idx_d       = idx_base_s;
        pre_full_d  = pre_full_base_s;
        remaining_d = remaining_q;
        trig_pos_d  = trig_pos_q;
        force_d     = force_eff_s;
        done_d      = (state_d == ST_DONE);
        if (store_s) begin
            cap_addr_d  = bus_addr;
            cap_dat_d   = bus_dat;
            cap_flags_d = bus_flags;
            idx_d       = idx_base_s + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            if (idx_base_s == {DEPTH_LOG2{1'b1}}) begin
                pre_full_d = 1'b1;
            end else begin
                pre_full_d = pre_full_base_s;
            end
        end else begin
            cap_wr_d = 1'b0;
        end
        if (hit_s) begin
            trig_pos_d  = idx_base_s;
            remaining_d = post_cnt_q;
            force_d     = 1'b0;
        end else if (store_s && (st_eff_s == ST_POST)) begin
            remaining_d = remaining_q - 9'd1;
        end else begin
            remaining_d = remaining_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk25 or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample pipeline, index and trigger bookkeeping.
    always_ff @(posedge clk25 or negedge res_n) begin
        if (!res_n) begin
            cap_wr_q    <= 1'b0;
            cap_addr_q  <= 16'h0000;
            cap_dat_q   <= 16'h0000;
            cap_flags_q <= 4'h0;
            idx_q       <= {DEPTH_LOG2{1'b0}};
            pre_full_q  <= 1'b0;
            remaining_q <= 9'd0;
            trig_pos_q  <= {DEPTH_LOG2{1'b0}};
            force_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cap_wr_q    <= cap_wr_d;
            cap_addr_q  <= cap_addr_d;
            cap_dat_q   <= cap_dat_d;
            cap_flags_q <= cap_flags_d;
            idx_q       <= idx_d;
            pre_full_q  <= pre_full_d;
            remaining_q <= remaining_d;
            trig_pos_q  <= trig_pos_d;
            force_q     <= force_d;
            done_q      <= done_d;
        end
    end

    // CPU-writable trigger configuration.
    always_ff @(posedge clk25 or negedge res_n) begin
        if (!res_n) begin
            trig_addr_q <= 16'h0000;
            trig_mask_q <= 16'hFFFF;
            post_cnt_q  <= 9'h100;
        end else if (reg_wr) begin
            case (reg_sel)
                2'd1:    trig_addr_q <= reg_wdat;
                2'd2:    trig_mask_q <= reg_wdat;
                2'd3:    post_cnt_q  <= reg_wdat[8:0];
                default: trig_addr_q <= trig_addr_q;
            endcase
        end else begin
            trig_addr_q <= trig_addr_q;
        end
    end

    // Register readback mux.
    always_comb begin
        case (reg_sel)
            2'd0:    reg_rdat = {pre_full_q, 9'b0, force_q, 1'b0, 2'b0, state_q};
            2'd1:    reg_rdat = trig_addr_q;
            2'd2:    reg_rdat = trig_mask_q;
            2'd3:    reg_rdat = {7'b0, post_cnt_q};
            default: reg_rdat = 16'h0000;
        endcase
    end

    assign cap_wr    = cap_wr_q;
    assign cap_addr  = cap_addr_q;
    assign cap_dat   = cap_dat_q;
    assign cap_flags = cap_flags_q;
    assign state     = state_q;
    assign trig_pos  = trig_pos_q;
    assign done      = done_q;

endmodule

// File: tb/tb_capture_ctl.sv
// Scoreboard bench for capture_ctl: stimulus queues expected samples, a monitor
// pops and compares on every cap_wr pulse; directed checks cover status and boundaries.
module tb_capture_ctl;

    logic        clk25 = 1'b0;
    logic        res_n;
    logic        bus_strobe;
    logic [15:0] bus_addr, bus_dat;
    logic [3:0]  bus_flags;
    logic        reg_wr;
    logic [1:0]  reg_sel;
    logic [15:0] reg_wdat;
    logic [15:0] reg_rdat;
    logic        cap_wr;
    logic [15:0] cap_addr, cap_dat;
    logic [3:0]  cap_flags;
    logic [1:0]  state;
    logic [8:0]  trig_pos;
    logic        done;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_base;
    logic [35:0] exp_q[$];

    capture_ctl #(.DEPTH_LOG2(9)) dut (
        .clk25(clk25), .res_n(res_n),
        .bus_strobe(bus_strobe), .bus_addr(bus_addr), .bus_dat(bus_dat), .bus_flags(bus_flags),
        .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_wdat(reg_wdat), .reg_rdat(reg_rdat),
        .cap_wr(cap_wr), .cap_addr(cap_addr), .cap_dat(cap_dat), .cap_flags(cap_flags),
        .state(state), .trig_pos(trig_pos), .done(done)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every capture pulse must match the oldest expected sample.
    always @(negedge clk25) begin
        if (res_n && cap_wr) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cap_unexpected: got %h expected no pulse", {cap_addr, cap_dat, cap_flags});
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({cap_addr, cap_dat, cap_flags} !== e) begin
                    errors++;
                    $display("FAIL cap_sample: got %h expected %h", {cap_addr, cap_dat, cap_flags}, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk25);
            #2;
        end
    endtask

    // Drive one strobe for one cycle; consecutive calls give back-to-back strobes.
    task automatic strobe(input logic [15:0] a, input logic [15:0] d, input logic [3:0] f, input bit exp);
        bus_strobe = 1'b1;
        bus_addr   = a;
        bus_dat    = d;
        bus_flags  = f;
        if (exp) exp_q.push_back({a, d, f});
        @(posedge clk25);
        #2;
        bus_strobe = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [15:0] d);
        reg_wr   = 1'b1;
        reg_sel  = sel;
        reg_wdat = d;
        @(posedge clk25);
        #2;
        reg_wr  = 1'b0;
        reg_sel = 2'd0;
    endtask

    task automatic read_check(input string name, input logic [1:0] sel, input logic [15:0] exp);
        reg_sel = sel;
        #1;
        check(name, {16'h0, reg_rdat}, {16'h0, exp});
        reg_sel = 2'd0;
    endtask

    task automatic drain_check(input string name, input int exp_pulses);
        idle(2);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_pulses"}, pulse_cnt - pulse_base, exp_pulses);
        pulse_base = pulse_cnt;
    endtask

    localparam logic [15:0] TRIG = 16'o177716;

    initial begin
        res_n = 1'b0; bus_strobe = 1'b0; bus_addr = 16'h0; bus_dat = 16'h0; bus_flags = 4'h0;
        reg_wr = 1'b0; reg_sel = 2'd0; reg_wdat = 16'h0;
        pulse_base = 0;
        idle(3);
        res_n = 1'b1;
        idle(1);

        // Reset values, then strobes while IDLE
        check("rst_state", state, 0);
        check("rst_done", done, 0);
        check("rst_cap_wr", cap_wr, 0);
        check("rst_trig_pos", trig_pos, 0);
        read_check("rst_ctrl", 2'd0, 16'h0000);
        read_check("rst_addr", 2'd1, 16'h0000);
        read_check("rst_mask", 2'd2, 16'hFFFF);
        read_check("rst_post", 2'd3, 16'h0100);
        for (int i = 0; i < 5; i++) strobe(16'(i), 16'hA000 + 16'(i), 4'h1, 1'b0);
        check("idle_state", state, 0);
        read_check("idle_ctrl", 2'd0, 16'h0000);
        drain_check("idle", 0);

        // Address trigger at sample 10 with POST=3
        reg_write(2'd2, 16'hFFFF);
        reg_write(2'd1, TRIG);
        reg_write(2'd3, 16'd3);
        read_check("addr_rb", 2'd1, TRIG);
        read_check("post_rb", 2'd3, 16'd3);
        reg_write(2'd0, 16'h0001);
        check("arm_state", state, 1);
        for (int i = 0; i < 10; i++) strobe(16'(i), 16'hB000 + 16'(i), 4'(i), 1'b1);
        check("pre_trig_state", state, 1);
        strobe(TRIG, 16'hB0AA, 4'h2, 1'b1);
        check("trig_state", state, 2);
        check("trig_pos10", trig_pos, 10);
        for (int i = 0; i < 5; i++) begin
            strobe(16'h0100 + 16'(i), 16'hC000 + 16'(i), 4'h4, i < 3);
            if (i == 1) check("done_before_last", done, 0);
            if (i == 2) begin
                check("done_on_last", done, 1);
                check("cap_wr_on_last", cap_wr, 1);
            end
        end
        check("post_state_done", state, 3);
        read_check("done_ctrl", 2'd0, 16'h0003);
        drain_check("post3", 14);

        // POST=0: trigger on the first sample goes straight to DONE
        reg_write(2'd3, 16'd0);
        reg_write(2'd0, 16'h0001);
        check("p0_armed", state, 1);
        strobe(TRIG, 16'hD00D, 4'h8, 1'b1);
        check("p0_state", state, 3);
        check("p0_trig_pos", trig_pos, 0);
        check("p0_done", done, 1);
        strobe(TRIG, 16'hD00E, 4'h8, 1'b0);
        drain_check("post0", 1);

        // Wrap past 512 samples, then FORCE
        reg_write(2'd3, 16'h0100);
        reg_write(2'd0, 16'h0001);
        for (int i = 0; i < 600; i++) strobe(16'(i), 16'(i) ^ 16'h5A5A, 4'(i), 1'b1);
        check("wrap_state", state, 1);
        reg_write(2'd0, 16'h0004);
        read_check("force_pending_ctrl", 2'd0, 16'h8021);
        strobe(16'h0001, 16'hF0F0, 4'h3, 1'b1);
        check("force_state", state, 2);
        check("force_trig_pos", trig_pos, 88);
        read_check("force_ctrl", 2'd0, 16'h8002);
        drain_check("force", 601);

        // ARM + strobe coincident, then ABORT + strobe coincident
        reg_write(2'd0, 16'h0002);
        check("abort_state", state, 0);
        reg_wr = 1'b1; reg_sel = 2'd0; reg_wdat = 16'h0001;
        strobe(TRIG, 16'h1111, 4'h5, 1'b1);
        reg_wr = 1'b0;
        check("armstb_state", state, 2);
        check("armstb_trig_pos", trig_pos, 0);
        read_check("armstb_ctrl", 2'd0, 16'h0002);
        reg_wr = 1'b1; reg_sel = 2'd0; reg_wdat = 16'h0002;
        strobe(16'h0042, 16'h2222, 4'h6, 1'b0);
        reg_wr = 1'b0;
        check("abortstb_state", state, 0);
        drain_check("coincident", 1);

        // Asynchronous reset during POST with cap_wr high
        reg_write(2'd1, 16'h1234);
        reg_write(2'd2, 16'h00F0);
        reg_write(2'd0, 16'h0001);
        strobe(16'h0030, 16'h3333, 4'h7, 1'b1);
        idle(2);
        check("pre_rst_state", state, 2);
        strobe(16'h0031, 16'h4444, 4'h7, 1'b0);
        check("pre_rst_cap_wr", cap_wr, 1);
        #1;
        res_n = 1'b0;
        #1;
        check("arst_cap_wr", cap_wr, 0);
        check("arst_state", state, 0);
        check("arst_done", done, 0);
        check("arst_trig_pos", trig_pos, 0);
        read_check("arst_addr", 2'd1, 16'h0000);
        read_check("arst_mask", 2'd2, 16'hFFFF);
        read_check("arst_post", 2'd3, 16'h0100);
        read_check("arst_ctrl", 2'd0, 16'h0000);
        idle(2);
        res_n = 1'b1;
        pulse_base = pulse_cnt;
        drain_check("arst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctl.md
# capture_ctl

Trigger sequencer for the bus-capture buffer. Samples completed bus cycles, streams them into the 512-entry capture RAM as one-cycle `cap_wr` pulses while armed, detects a masked address trigger, stores a programmable number of post-trigger samples, then stops and raises `done`. It sits between the CPU bus snoop and the capture buffer. The CPU configures and monitors it through a four-register port.

## Interface
- `DEPTH_LOG2`, 9, log2 of capture RAM depth; sets the width of the sample index and `trig_pos`.
- `clk25`  in  1  system clock; everything is on its rising edge.
- `res_n`  in  1  asynchronous, active-low reset.
- `bus_strobe`  in  1  one-cycle pulse per completed bus cycle.
- `bus_addr`  in  16  bus address, valid with `bus_strobe`.
- `bus_dat`  in  16  bus data, valid with `bus_strobe`.
- `bus_flags`  in  4  cycle flags (rd/wr/byte/iack), valid with `bus_strobe`.
- `reg_wr`  in  1  one-cycle register write strobe.
- `reg_sel`  in  2  register select: 0 = CTRL/STATUS, 1 = TRIG_ADDR, 2 = TRIG_MASK, 3 = POST_CNT.
- `reg_wdat`  in  16  register write data.
- `reg_rdat`  out  16  combinational readback of the register selected by `reg_sel`.
- `cap_wr`  out  1  capture write pulse, high exactly one cycle.
- `cap_addr`  out  16  registered sample address.
- `cap_dat`  out  16  registered sample data.
- `cap_flags`  out  4  registered sample flags.
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `trig_pos`  out  DEPTH_LOG2  sample index of the trigger sample.
- `done`  out  1  level; high in DONE.

## Operation
- CTRL write bits:
  - bit0 ARM: clears the sample index and `pre_full`, then enters ARMED.
  - bit1 ABORT: enters IDLE. ABORT wins if set together with ARM.
  - bit2 FORCE: forces a trigger on the next stored sample; valid only in ARMED.
- CTRL read: {`pre_full`, 9'b0, `trig_pending`, 1'b0, 2'b0, `state`}.
- TRIG_ADDR, TRIG_MASK, POST_CNT[8:0] read back as written.
- Match rule: `((bus_addr ^ TRIG_ADDR) & TRIG_MASK) == 0`. A mask of 0 matches every cycle.
- IDLE: strobes are ignored; no `cap_wr`.
- ARMED: every strobe is stored. If it matches (or FORCE is pending):
  - latch `trig_pos` = current sample index;
  - load remaining = POST_CNT;
  - if POST_CNT == 0, go to DONE; otherwise go to POST.
- POST: every strobe is stored and decrements remaining. The store that brings remaining to 0 moves the FSM to DONE.
- DONE: strobes are ignored and `done` = 1 until ARM or ABORT.
- Sample index: DEPTH_LOG2 bits, increments on every `cap_wr`, wraps 511→0.
- `pre_full`: sets on the first wrap after ARM and is sticky until the next ARM.
- Register writes in ARMED/POST take effect from the next strobe. POST_CNT is only sampled at the trigger.

## Timing
- Reset values:
  - all outputs 0; `state` = IDLE; index 0;
  - TRIG_ADDR 0, TRIG_MASK 16'hFFFF, POST_CNT 9'h100;
  - FORCE pending 0, `pre_full` 0.
- Latency: `bus_strobe` at cycle N → `cap_wr` = 1 in cycle N+1, with `cap_addr`/`cap_dat`/`cap_flags` holding cycle-N values. Data holds until the next store.
- `state` and `trig_pos` update at the same edge that raises `cap_wr` for the trigger sample.
- `done` rises at the edge that issues the final `cap_wr`.
- Back-to-back strobes give back-to-back `cap_wr` pulses. `cap_wr` is never high for two cycles on the same sample.
- `reg_wr` coinciding with `bus_strobe`: the control action applies first.
  - ARM: the strobe is stored as sample 0 of the new run.
  - ABORT: the strobe is dropped.
- FORCE and an address match on the same sample count as a single trigger.
- `res_n` low mid-run clears everything asynchronously. Any `cap_wr` in flight is deasserted immediately.

## Test plan
- Reset, then 5 strobes with no ARM → no `cap_wr`; `state` = 0; CTRL reads 16'h0000.
- MASK = FFFF, ADDR = 0o177716, POST = 3, ARM; 10 non-matching strobes, then a match at sample 10, then 5 more strobes → exactly 14 `cap_wr` pulses; `trig_pos` = 10; `done` rises on the 14th pulse; the last strobe is not stored.
- POST = 0; trigger on the first strobe → 1 `cap_wr`; `state` goes 1→3 in one edge; `trig_pos` = 0.
- ARM, 600 non-matching strobes, then FORCE + 1 strobe → `pre_full` = 1; `trig_pos` = 600 mod 512 = 88; `state` = POST (POST = 256).
- ARM and strobe in the same cycle, then ABORT and strobe in the same cycle → first strobe stored with index 0; second strobe dropped; `state` = IDLE.
- Assert `res_n` low during POST with `cap_wr` high → `cap_wr`, `state` and `done` go to 0 without waiting for a clock; registers return to their reset values.
